// File: rtl/axi_grant_scheduler.sv
// Arbitrates the shared AXI master port between the I$ and D$ and tracks one
// address/data/response transaction per grant, flagging illegal handshakes.
module axi_grant_scheduler #(
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic m_awvalid,
    input  logic m_awready,
    input  logic m_wvalid,
    input  logic m_wready,
    input  logic m_wlast,
    input  logic m_bvalid,
    input  logic m_bready,
    input  logic m_arvalid,
    input  logic m_arready,
    input  logic m_rvalid,
    input  logic m_rready,
    input  logic m_rlast,
    output logic gnt_i,
    output logic gnt_d,
    output logic busy,
    output logic protocol_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        WRESP = 3'd4
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    state_t           state;
    state_t           state_nxt;
    src_t             last_served;
    src_t             last_served_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic             aw_done;
    logic             aw_done_nxt;
    logic             w_done;
    logic             w_done_nxt;
    logic             gnt_i_nxt;
    logic             gnt_d_nxt;
    logic             err_nxt;
    logic             release_grant;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic held_req;

    assign aw_hs    = m_awvalid & m_awready;
    assign w_hs     = m_wvalid  & m_wready;
    assign b_hs     = m_bvalid  & m_bready;
    assign ar_hs    = m_arvalid & m_arready;
    assign r_hs     = m_rvalid  & m_rready;
    assign held_req = gnt_i ? req_i : req_d;

    // Next-state and next-output logic; outputs follow the next state so they are registered.
    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        wait_cnt_nxt    = wait_cnt;
        aw_done_nxt     = aw_done;
        w_done_nxt      = w_done;
        gnt_i_nxt       = gnt_i;
        gnt_d_nxt       = gnt_d;
        err_nxt         = protocol_err;
        release_grant   = 1'b0;

        case (state)
            IDLE: begin
                if (r_hs || b_hs) begin
                    err_nxt = 1'b1;
                end
                if (req_i && (!req_d || last_served == SRC_D)) begin
                    state_nxt       = GRANT;
                    gnt_i_nxt       = 1'b1;
                    last_served_nxt = SRC_I;
                    wait_cnt_nxt    = '0;
                end else if (req_d) begin
                    state_nxt       = GRANT;
                    gnt_d_nxt       = 1'b1;
                    last_served_nxt = SRC_D;
                    wait_cnt_nxt    = '0;
                end
            end

            GRANT: begin
                if (r_hs || b_hs) begin
                    err_nxt = 1'b1;
                end
                if (w_hs && m_wlast) begin
                    w_done_nxt = 1'b1;
                end
                // A simultaneous AR/AW is resolved towards the write path.
                if (aw_hs) begin
                    state_nxt   = WDATA;
                    aw_done_nxt = 1'b1;
                    if (ar_hs) begin
                        err_nxt = 1'b1;
                    end
                end else if (ar_hs) begin
                    state_nxt = RDATA;
                end else if (!held_req || wait_cnt == CNT_LAST) begin
                    release_grant = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end

            RDATA: begin
                if (r_hs && m_rlast) begin
                    release_grant = 1'b1;
                end
            end

            WDATA: begin
                if (w_hs && m_wlast) begin
                    w_done_nxt = 1'b1;
                end
                if (aw_done && (w_done || (w_hs && m_wlast))) begin
                    state_nxt = WRESP;
                end
            end

            WRESP: begin
                if (w_hs) begin
                    err_nxt = 1'b1;
                end
                if (b_hs) begin
                    release_grant = 1'b1;
                end
            end

            default: begin
                release_grant = 1'b1;
            end
        endcase

        if (release_grant) begin
            state_nxt   = IDLE;
            gnt_i_nxt   = 1'b0;
            gnt_d_nxt   = 1'b0;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_served  <= SRC_D;
            wait_cnt     <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            gnt_i        <= 1'b0;
            gnt_d        <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_served  <= last_served_nxt;
            wait_cnt     <= wait_cnt_nxt;
            aw_done      <= aw_done_nxt;
            w_done       <= w_done_nxt;
            gnt_i        <= gnt_i_nxt;
            gnt_d        <= gnt_d_nxt;
            busy         <= (state_nxt != IDLE);
            protocol_err <= err_nxt;
        end
    end

endmodule
